// File: rtl/vga_sync_receiver.sv
// VGA sink: samples syncs and 12-bit RGB on the pixel strobe, recovers pixel
// coordinates, verifies line/frame timing, and emits validated pixels once locked.
module vga_sync_receiver #(
    parameter int H_ACTIVE        = 640,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int V_TOTAL         = 525,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pixEn,
    input  logic        i_hSync,
    input  logic        i_vSync,
    input  logic [3:0]  i_VGA_R,
    input  logic [3:0]  i_VGA_G,
    input  logic [3:0]  i_VGA_B,
    output logic        o_locked,
    output logic        o_pixValid,
    output logic [9:0]  o_pixX,
    output logic [8:0]  o_pixY,
    output logic [11:0] o_pixColor,
    output logic        o_frameStart,
    output logic        o_hError,
    output logic        o_vError,
    output logic [7:0]  o_errCount
);

    localparam logic [9:0] HT  = 10'(H_TOTAL);
    localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] HSW = 10'(H_SYNC);
    localparam logic [9:0] HX0 = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HX1 = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] VSW = 10'(V_SYNC);
    localparam logic [9:0] VY0 = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VY1 = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      r_state, w_next;
    logic        r_hsPrev, r_vsPrev, r_hPend, r_vPend;
    logic [9:0]  r_hCount, r_vCount;
    logic        r_locked, r_pixValid, r_frameStart, r_hError, r_vError;
    logic [9:0]  r_pixX;
    logic [8:0]  r_pixY;
    logic [11:0] r_pixColor;
    logic [7:0]  r_errCount;

    logic        w_hs, w_vs, w_hLead, w_vStart, w_checking;
    logic        w_hErrRaw, w_vErrRaw, w_hErr, w_vErr, w_err, w_inWin, w_valid;
    logic [9:0]  w_hcNext, w_vcNext;
    logic [8:0]  w_errSum;

    assign w_hs     = SYNC_ACTIVE_LOW ? ~i_hSync : i_hSync;
    assign w_vs     = SYNC_ACTIVE_LOW ? ~i_vSync : i_vSync;
    assign w_hLead  = w_hs & ~r_hsPrev;
    assign w_vStart = w_hLead & w_vs & ~r_vsPrev;

    // Counts are the value belonging to the current sample, saturating at TOTAL.
    assign w_hcNext = w_hLead ? 10'd0 : ((r_hCount == HT) ? r_hCount : r_hCount + 10'd1);
    assign w_vcNext = !w_hLead ? r_vCount :
                      w_vStart ? 10'd0 :
                      ((r_vCount == VT) ? r_vCount : r_vCount + 10'd1);

    assign w_hErrRaw = w_hLead ? (r_hCount != HT1)
                               : ((w_hcNext == HT && r_hCount != HT) ||
                                  (!w_hs && r_hPend && w_hcNext != HSW));
    assign w_vErrRaw = w_hLead & (w_vStart ? (r_vCount != VT1)
                                           : ((w_vcNext == VT && r_vCount != VT) ||
                                              (!w_vs && r_vPend && w_vcNext != VSW)));

    // Timing is only judged once a frame boundary has been seen.
    assign w_checking = (r_state != SEARCH);
    assign w_hErr     = w_hErrRaw & w_checking;
    assign w_vErr     = w_vErrRaw & w_checking;
    assign w_err      = w_hErr | w_vErr;
    assign w_inWin    = (w_hcNext >= HX0) && (w_hcNext <= HX1) &&
                        (w_vcNext >= VY0) && (w_vcNext <= VY1);
    assign w_valid    = (r_state == LOCKED) & ~w_err & w_inWin;
    assign w_errSum   = {1'b0, r_errCount} + {8'd0, w_hErr} + {8'd0, w_vErr};

    always_comb begin
        w_next = r_state;
        if (i_pixEn) begin
            case (r_state)
                SEARCH:  if (w_vStart) w_next = CHECK;
                CHECK:   if (w_err) w_next = SEARCH;
                         else if (w_vStart) w_next = LOCKED;
                LOCKED:  if (w_err) w_next = SEARCH;
                default: w_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= SEARCH;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hsPrev     <= 1'b0;
            r_vsPrev     <= 1'b0;
            r_hPend      <= 1'b0;
            r_vPend      <= 1'b0;
            r_hCount     <= 10'd0;
            r_vCount     <= 10'd0;
            r_locked     <= 1'b0;
            r_pixValid   <= 1'b0;
            r_frameStart <= 1'b0;
            r_hError     <= 1'b0;
            r_vError     <= 1'b0;
            r_pixX       <= 10'd0;
            r_pixY       <= 9'd0;
            r_pixColor   <= 12'd0;
            r_errCount   <= 8'd0;
        end else begin
            r_pixValid   <= 1'b0;
            r_frameStart <= 1'b0;
            r_hError     <= 1'b0;
            r_vError     <= 1'b0;
            if (i_pixEn) begin
                r_hsPrev <= w_hs;
                r_hCount <= w_hcNext;
                if (w_hLead)   r_hPend <= 1'b1;
                else if (!w_hs) r_hPend <= 1'b0;
                if (w_hLead) begin
                    r_vsPrev <= w_vs;
                    r_vCount <= w_vcNext;
                    if (w_vStart)   r_vPend <= 1'b1;
                    else if (!w_vs) r_vPend <= 1'b0;
                end
                r_locked     <= (w_next == LOCKED);
                r_frameStart <= w_vStart && (w_next == LOCKED);
                r_hError     <= w_hErr;
                r_vError     <= w_vErr;
                r_pixValid   <= w_valid;
                if (w_valid) begin
                    r_pixX     <= w_hcNext - HX0;
                    r_pixY     <= 9'(w_vcNext - VY0);
                    r_pixColor <= {i_VGA_R, i_VGA_G, i_VGA_B};
                end
                r_errCount <= w_errSum[8] ? 8'hFF : w_errSum[7:0];
            end
        end
    end

    assign o_locked     = r_locked;
    assign o_pixValid   = r_pixValid;
    assign o_pixX       = r_pixX;
    assign o_pixY       = r_pixY;
    assign o_pixColor   = r_pixColor;
    assign o_frameStart = r_frameStart;
    assign o_hError     = r_hError;
    assign o_vError     = r_vError;
    assign o_errCount   = r_errCount;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster: one active-low and one
// active-high instance driven by the same timing, checked against an index-based model.
module tb_vga_sync_receiver;

    localparam int HA = 8, HS = 3, HB = 2, HT = 16;
    localparam int VA = 4, VS = 2, VB = 2, VT = 10;

    logic clk = 1'b0;
    logic rst, pe, hs_a, vs_a;
    logic [3:0] R, G, B;

    logic        lo_locked, lo_valid, lo_fs, lo_he, lo_ve;
    logic [9:0]  lo_x;
    logic [8:0]  lo_y;
    logic [11:0] lo_col;
    logic [7:0]  lo_ec;
    logic        hi_locked, hi_valid, hi_fs, hi_he, hi_ve;
    logic [9:0]  hi_x;
    logic [8:0]  hi_y;
    logic [11:0] hi_col;
    logic [7:0]  hi_ec;

    always #5 clk = ~clk;

    vga_sync_receiver #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(1'b1)) dut_lo (
        .i_clk(clk), .i_reset(rst), .i_pixEn(pe), .i_hSync(~hs_a), .i_vSync(~vs_a),
        .i_VGA_R(R), .i_VGA_G(G), .i_VGA_B(B),
        .o_locked(lo_locked), .o_pixValid(lo_valid), .o_pixX(lo_x), .o_pixY(lo_y),
        .o_pixColor(lo_col), .o_frameStart(lo_fs), .o_hError(lo_he), .o_vError(lo_ve),
        .o_errCount(lo_ec));

    vga_sync_receiver #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
        .i_clk(clk), .i_reset(rst), .i_pixEn(pe), .i_hSync(hs_a), .i_vSync(vs_a),
        .i_VGA_R(R), .i_VGA_G(G), .i_VGA_B(B),
        .o_locked(hi_locked), .o_pixValid(hi_valid), .o_pixX(hi_x), .o_pixY(hi_y),
        .o_pixColor(hi_col), .o_frameStart(hi_fs), .o_hError(hi_he), .o_vError(hi_ve),
        .o_errCount(hi_ec));

    int tests = 0, fails = 0;

    // Reference model: positions are derived from sample / line indices of the last edges.
    int  m_n, m_lastH, m_curL, m_lastV, m_mode;
    bit  m_hsP, m_vsP, m_hPend, m_vPend;
    bit  e_locked, e_valid, e_fs, e_he, e_ve;
    logic [9:0]  e_x;
    logic [8:0]  e_y;
    logic [11:0] e_col;
    int  e_ec;

    // Per-frame observations from the active-low instance
    int vcnt, fx, fy, lx, ly;
    bit seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_lastH = -1; m_curL = -1; m_lastV = -1; m_mode = 0;
        m_hsP = 0; m_vsP = 0; m_hPend = 0; m_vPend = 0;
        e_locked = 0; e_valid = 0; e_fs = 0; e_he = 0; e_ve = 0;
        e_x = '0; e_y = '0; e_col = '0; e_ec = 0;
    endtask

    task automatic model_sample(input bit hs, input bit vs, input logic [11:0] col);
        bit hl, vl, he, ve, err, vstart;
        int hd, vd, hc, vc, om;
        hl = hs && !m_hsP;
        hd = m_n - m_lastH;
        hc = hl ? 0 : (hd > HT ? HT : hd);
        if (hl) he = (hd != HT);
        else    he = (hd == HT) || (!hs && m_hPend && hc != HS);
        if (hl) m_hPend = 1; else if (!hs) m_hPend = 0;
        if (hl) m_lastH = m_n;
        m_hsP = hs;
        m_n++;
        vl = 0; ve = 0;
        if (hl) begin
            m_curL++;
            vl = vs && !m_vsP;
            vd = m_curL - m_lastV;
            if (vl) begin
                ve = (vd != VT);
                m_lastV = m_curL;
                m_vPend = 1;
            end else begin
                ve = (vd == VT) || (!vs && m_vPend && (vd > VT ? VT : vd) != VS);
                if (!vs) m_vPend = 0;
            end
            m_vsP = vs;
        end
        vd = m_curL - m_lastV;
        vc = vd > VT ? VT : vd;
        om = m_mode;
        err = (he || ve) && om != 0;
        vstart = hl && vl;
        if (om == 0) begin
            if (vstart) m_mode = 1;
        end else if (err) m_mode = 0;
        else if (om == 1 && vstart) m_mode = 2;
        e_he = he && om != 0;
        e_ve = ve && om != 0;
        e_locked = (m_mode == 2);
        e_fs = vstart && m_mode == 2;
        if (om == 2 && !err && hc >= HS + HB && hc <= HS + HB + HA - 1 &&
            vc >= VS + VB && vc <= VS + VB + VA - 1) begin
            e_valid = 1;
            e_x = 10'(hc - (HS + HB));
            e_y = 9'(vc - (VS + VB));
            e_col = col;
        end
        e_ec = e_ec + int'(e_he) + int'(e_ve);
        if (e_ec > 255) e_ec = 255;
    endtask

    task automatic check_outs();
        chk("lo_locked", 32'(lo_locked), 32'(e_locked));
        chk("lo_valid",  32'(lo_valid),  32'(e_valid));
        chk("lo_x",      32'(lo_x),      32'(e_x));
        chk("lo_y",      32'(lo_y),      32'(e_y));
        chk("lo_col",    32'(lo_col),    32'(e_col));
        chk("lo_fs",     32'(lo_fs),     32'(e_fs));
        chk("lo_he",     32'(lo_he),     32'(e_he));
        chk("lo_ve",     32'(lo_ve),     32'(e_ve));
        chk("lo_ec",     32'(lo_ec),     32'(e_ec));
        chk("hi_locked", 32'(hi_locked), 32'(e_locked));
        chk("hi_valid",  32'(hi_valid),  32'(e_valid));
        chk("hi_x",      32'(hi_x),      32'(e_x));
        chk("hi_y",      32'(hi_y),      32'(e_y));
        chk("hi_col",    32'(hi_col),    32'(e_col));
        chk("hi_fs",     32'(hi_fs),     32'(e_fs));
        chk("hi_he",     32'(hi_he),     32'(e_he));
        chk("hi_ve",     32'(hi_ve),     32'(e_ve));
        chk("hi_ec",     32'(hi_ec),     32'(e_ec));
    endtask

    task automatic step(input bit r, input bit p, input bit hs, input bit vs, input logic [11:0] col);
        rst = r; pe = p; hs_a = hs; vs_a = vs; {R, G, B} = col;
        e_valid = 0; e_fs = 0; e_he = 0; e_ve = 0;
        if (r) model_reset();
        else if (p) model_sample(hs, vs, col);
        @(negedge clk);
        check_outs();
        if (lo_valid) begin
            if (!seen) begin fx = lo_x; fy = lo_y; seen = 1; end
            lx = lo_x; ly = lo_y;
            vcnt++;
        end
    endtask

    task automatic idle_gap();
        while ($urandom_range(0, 3) == 0)
            step(0, 0, 1'($urandom), 1'($urandom), 12'($urandom));
    endtask

    // One frame of nl lines; line 'bad' gets a one-pixel-short hSync; a reset
    // pulse is inserted before pixel (rl, rp).
    task automatic gen_frame(input int nl, input int bad, input int rl, input int rp);
        vcnt = 0; seen = 0;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < HT; p++) begin
                idle_gap();
                if (l == rl && p == rp)
                    step(1, 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
                step(0, 1, p < ((l == bad) ? HS - 1 : HS), l < VS, 12'($urandom));
            end
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 6; i++)
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
        chk("reset_locked", 32'(lo_locked), 32'd0);
        chk("reset_errcount", 32'(lo_ec), 32'd0);

        gen_frame(VT, -1, -1, -1);
        chk("check_not_locked", 32'(lo_locked), 32'd0);
        gen_frame(VT, -1, -1, -1);
        chk("locked_2nd_vsync", 32'(lo_locked), 32'd1);
        chk("pix_per_frame", 32'(vcnt), 32'(HA * VA));
        chk("first_pix", {16'(fx), 16'(fy)}, 32'd0);
        chk("last_pix", {16'(lx), 16'(ly)}, {16'(HA - 1), 16'(VA - 1)});

        gen_frame(VT, 5, -1, -1);
        chk("hwidth_unlock", 32'(lo_locked), 32'd0);
        chk("hwidth_errcount", 32'(lo_ec), 32'd1);
        gen_frame(VT, -1, -1, -1);
        gen_frame(VT, -1, -1, -1);
        chk("relock", 32'(lo_locked), 32'd1);
        chk("relock_errcount", 32'(lo_ec), 32'd1);
        chk("relock_pix", 32'(vcnt), 32'(HA * VA));

        gen_frame(VT + 1, -1, -1, -1);
        chk("long_frame_unlock", 32'(lo_locked), 32'd0);
        chk("long_frame_errcount", 32'(lo_ec), 32'd2);
        gen_frame(VT, -1, -1, -1);
        gen_frame(VT, -1, -1, -1);
        chk("relock2", 32'(lo_locked), 32'd1);

        gen_frame(VT, -1, VS + VB + 1, HS + HB + 2);
        chk("post_reset_unlocked", 32'(lo_locked), 32'd0);
        chk("post_reset_errcount", 32'(lo_ec), 32'd0);
        gen_frame(VT, -1, -1, -1);
        chk("post_reset_check", 32'(lo_locked), 32'd0);
        gen_frame(VT, -1, -1, -1);
        chk("post_reset_relock", 32'(lo_locked), 32'd1);
        chk("post_reset_pix", 32'(vcnt), 32'(HA * VA));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
